// File: rtl/pu_loader_pkg.sv
// Shared definitions for pu_loader: state encoding, lane count and processing-unit latency.
package pu_loader_pkg;

    localparam int unsigned LANES      = 4;
    localparam int unsigned PU_LATENCY = 2;
    localparam int unsigned XLEN_DEF   = 5;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned WCNT_W  = 2;

    localparam logic [STATE_W-1:0] ST_COLLECT = 3'd0;
    localparam logic [STATE_W-1:0] ST_ISSUE   = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT    = 3'd2;
    localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd3;
    localparam logic [STATE_W-1:0] ST_OUT     = 3'd4;

    // True when the word being accepted completes the frame.
    function automatic logic last_word(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(LANES - 1);
    endfunction

endpackage

// File: rtl/pu_lane_shift.sv
// Four operand lane registers for the processing unit, written one at a time by word index.
module pu_lane_shift
    import pu_loader_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_sel,
    input  logic [XLEN-1:0]  wr_data,
    output logic [XLEN-1:0]  num1,
    output logic [XLEN-1:0]  num2,
    output logic [XLEN-1:0]  num3,
    output logic [XLEN-1:0]  num4
);

    logic [XLEN-1:0] lanes [LANES];

    // Lanes keep their contents until overwritten; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(LANES); i++) begin
                lanes[i] <= '0;
            end
        end else if (wr_en) begin
            lanes[wr_sel] <= wr_data;
        end
    end

    assign num1 = lanes[0];
    assign num2 = lanes[1];
    assign num3 = lanes[2];
    assign num4 = lanes[3];

endmodule

// File: rtl/pu_loader.sv
// Frame loader for a 4-input processing unit: collects four words, issues them, captures the result.
// Optional PU_LOADER_FRAME_CNT_EN adds an 8-bit count of completed output handshakes.
module pu_loader
    import pu_loader_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
`ifdef PU_LOADER_FRAME_CNT_EN
    output logic [7:0]      frame_cnt,
`endif
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_data,
    output logic            in_ready,
    input  logic            flush,
    output logic [XLEN-1:0] num1,
    output logic [XLEN-1:0] num2,
    output logic [XLEN-1:0] num3,
    output logic [XLEN-1:0] num4,
    output logic            lane_valid,
    input  logic [XLEN-1:0] res_in,
    output logic            out_valid,
    output logic [XLEN-1:0] out_data,
    input  logic            out_ready
);

    logic [STATE_W-1:0] state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [WCNT_W-1:0]  wait_cnt, wait_cnt_nx;
    logic               out_valid_nx;
    logic [XLEN-1:0]    out_data_nx;
    logic               lane_wr;
    logic               frame_done;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_COLLECT;
            cnt        <= '0;
            wait_cnt   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            lane_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            wait_cnt   <= wait_cnt_nx;
            out_valid  <= out_valid_nx;
            out_data   <= out_data_nx;
            lane_valid <= (state_nx == ST_ISSUE);
        end
    end

    // Next-state logic; flush overrides every handshake.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        wait_cnt_nx  = wait_cnt;
        out_valid_nx = out_valid;
        out_data_nx  = out_data;
        in_ready     = 1'b0;
        lane_wr      = 1'b0;
        frame_done   = 1'b0;

        if (flush) begin
            state_nx     = ST_COLLECT;
            cnt_nx       = '0;
            out_valid_nx = 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        lane_wr = 1'b1;
                        cnt_nx  = cnt + CNT_W'(1);
                        if (last_word(cnt)) begin
                            state_nx = ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // Extra WAIT cycles beyond one cover deeper processing units.
                    wait_cnt_nx = WCNT_W'(PU_LATENCY - 2);
                    state_nx    = ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state_nx = ST_CAPTURE;
                    end else begin
                        wait_cnt_nx = wait_cnt - WCNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    out_data_nx  = res_in;
                    out_valid_nx = 1'b1;
                    state_nx     = ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_nx = 1'b0;
                        frame_done   = 1'b1;
                        state_nx     = ST_COLLECT;
                    end
                end
                default: begin
                    state_nx = ST_COLLECT;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    pu_lane_shift #(
        .XLEN (XLEN)
    ) u_lanes (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (lane_wr),
        .wr_sel  (cnt),
        .wr_data (in_data),
        .num1    (num1),
        .num2    (num2),
        .num3    (num3),
        .num4    (num4)
    );

`ifdef PU_LOADER_FRAME_CNT_EN
    // Completed output handshakes; flush cannot complete one, so it never counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 8'(1);
        end
    end
`else
    logic unused_frame_done;
    assign unused_frame_done = frame_done;
`endif

endmodule

// File: tb/tb_pu_loader.sv
// Randomized and directed bench for pu_loader against a cycle-count reference model.
module tb_pu_loader;

    localparam int unsigned XLEN = 5;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic [XLEN-1:0] in_data = '0;
    logic            in_ready;
    logic            flush = 1'b0;
    logic [XLEN-1:0] num1, num2, num3, num4;
    logic            lane_valid;
    logic [XLEN-1:0] res_in = '0;
    logic            out_valid;
    logic [XLEN-1:0] out_data;
    logic            out_ready = 1'b0;
`ifdef PU_LOADER_FRAME_CNT_EN
    logic [7:0]      frame_cnt;
`endif

    int total = 0;
    int bad = 0;

    // Reference model: words in current frame, cycles since frame completed, captured result.
    logic [XLEN-1:0] m_lane [4];
    int              m_words;
    int              m_busy;
    logic            m_ov;
    logic [XLEN-1:0] m_od;
    int              m_frames;

    pu_loader #(.XLEN(XLEN)) dut (
`ifdef PU_LOADER_FRAME_CNT_EN
        .frame_cnt  (frame_cnt),
`endif
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flush      (flush),
        .num1       (num1),
        .num2       (num2),
        .num3       (num3),
        .num4       (num4),
        .lane_valid (lane_valid),
        .res_in     (res_in),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_lane[i] = '0;
        m_words  = 0;
        m_busy   = 0;
        m_ov     = 1'b0;
        m_od     = '0;
        m_frames = 0;
    endtask

    task automatic check_all(input logic fl);
        check("in_ready",   32'(in_ready),   32'((m_busy == 0) && !fl));
        check("lane_valid", 32'(lane_valid), 32'(m_busy == 1));
        check("out_valid",  32'(out_valid),  32'(m_ov));
        check("out_data",   32'(out_data),   32'(m_od));
        check("num1", 32'(num1), 32'(m_lane[0]));
        check("num2", 32'(num2), 32'(m_lane[1]));
        check("num3", 32'(num3), 32'(m_lane[2]));
        check("num4", 32'(num4), 32'(m_lane[3]));
`ifdef PU_LOADER_FRAME_CNT_EN
        check("frame_cnt", 32'(frame_cnt), 32'(m_frames % 256));
`endif
    endtask

    // One clock cycle: drive, check outputs before the edge, then advance the model.
    task automatic step(input logic iv, input logic [XLEN-1:0] d, input logic fl,
                        input logic ordy, input logic [XLEN-1:0] res);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        flush     = fl;
        out_ready = ordy;
        res_in    = res;
        #1;
        check_all(fl);
        @(posedge clk);
        if (fl) begin
            m_words = 0;
            m_busy  = 0;
            m_ov    = 1'b0;
        end else if (m_busy == 0) begin
            if (iv) begin
                m_lane[m_words] = d;
                m_words++;
                if (m_words == 4) begin
                    m_words = 0;
                    m_busy  = 1;
                end
            end
        end else if (m_busy < 1 + LAT) begin
            m_busy++;
        end else if (m_busy == 1 + LAT) begin
            m_od   = res;
            m_ov   = 1'b1;
            m_busy = m_busy + 1;
        end else if (ordy) begin
            m_ov     = 1'b0;
            m_busy   = 0;
            m_frames = m_frames + 1;
        end
    endtask

    // Asynchronous reset pulse placed away from any clock edge.
    task automatic pulse_rst();
        @(negedge clk);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all(1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic full_frame(input logic [XLEN-1:0] a, b, c, d, input logic [XLEN-1:0] res);
        step(1, a, 0, 0, '0);
        step(1, b, 0, 0, '0);
        step(1, c, 0, 0, '0);
        step(1, d, 0, 0, '0);
        step(0, '0, 0, 0, '0);
        step(0, '0, 0, 0, '0);
        step(0, '0, 0, 0, res);
        step(0, '0, 0, 1, '0);
    endtask

    initial begin
        model_reset();
        #2;
        check_all(1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back frame 1,2,3,4 with result 0x0A, then held output for 10 cycles.
        step(1, 5'd1, 0, 0, '0);
        step(1, 5'd2, 0, 0, '0);
        step(1, 5'd3, 0, 0, '0);
        step(1, 5'd4, 0, 0, '0);
        step(0, '0, 0, 0, 5'h11);
        step(0, '0, 0, 0, 5'h12);
        step(0, '0, 0, 0, 5'h0A);
        for (int i = 0; i < 10; i++) step(1, 5'(i), 0, 0, 5'(i + 3));
        step(0, '0, 0, 1, '0);
        step(0, '0, 0, 0, '0);

        // Gapped input.
        step(1, 5'h1F, 0, 0, '0);
        step(0, 5'h05, 0, 0, '0);
        step(1, 5'h00, 0, 0, '0);
        step(0, 5'h06, 0, 0, '0);
        step(1, 5'h15, 0, 0, '0);
        step(0, 5'h07, 0, 0, '0);
        step(1, 5'h0A, 0, 0, '0);
        step(0, '0, 0, 0, '0);
        step(0, '0, 0, 0, '0);
        step(0, '0, 0, 0, 5'h13);
        step(0, '0, 0, 1, '0);

        // Flush after two words, flush together with in_valid, then a fresh frame.
        step(1, 5'h08, 0, 0, '0);
        step(1, 5'h09, 0, 0, '0);
        step(1, 5'h1E, 1, 0, '0);
        full_frame(5'h01, 5'h02, 5'h03, 5'h04, 5'h1C);
        step(0, '0, 0, 0, '0);

        // Reset during WAIT.
        step(1, 5'h0B, 0, 0, '0);
        step(1, 5'h0C, 0, 0, '0);
        step(1, 5'h0D, 0, 0, '0);
        step(1, 5'h0E, 0, 0, '0);
        step(0, '0, 0, 0, '0);
        pulse_rst();
        for (int i = 0; i < 4; i++) step(0, '0, 0, 1, 5'h1B);

        // 256 complete frames (wraps the optional counter), then one flushed frame.
        for (int f = 0; f < 256; f++) begin
            full_frame(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
        end
        step(1, 5'h03, 0, 0, '0);
        step(1, 5'h04, 0, 0, '0);
        step(0, '0, 1, 1, '0);
        step(0, '0, 0, 0, '0);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                pulse_rst();
            end else begin
                step(logic'($urandom_range(0, 9) < 7), 5'($urandom),
                     logic'($urandom_range(0, 19) == 0),
                     logic'($urandom_range(0, 1)), 5'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pu_loader.md
PU_LOADER -- requirements
Module: pu_loader

Interface
REQ-001 Parameter XLEN, default 5, operand/result width in bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 in_valid  in  1  upstream word valid.
REQ-005 in_data  in  XLEN  upstream operand word.
REQ-006 in_ready  out  1  loader accepts in_data this cycle.
REQ-007 flush  in  1  synchronous abort of the current frame.
REQ-008 num1, num2, num3, num4  out  XLEN each  parallel operand lanes to the 4-input processing unit.
REQ-009 lane_valid  out  1  one-cycle pulse marking the cycle in which lanes are sampled by the processing unit.
REQ-010 res_in  in  XLEN  result returned by the processing unit.
REQ-011 out_valid  out  1  out_data holds a completed result.
REQ-012 out_data  out  XLEN  captured result.
REQ-013 out_ready  in  1  downstream accepts out_data.

Function
REQ-014 Handshake: a word transfers when in_valid=1 and in_ready=1 on a rising edge; a result transfers when out_valid=1 and out_ready=1.
REQ-015 States: COLLECT, ISSUE, WAIT, CAPTURE, OUT.
REQ-016 COLLECT: in_ready=1 unless flush=1; accepted words fill num1, num2, num3, num4 in arrival order; 2-bit count increments per accept; the 4th accept moves to ISSUE with count back to 0.
REQ-017 ISSUE lasts 1 cycle with lane_valid=1 and lanes stable; next state WAIT.
REQ-018 WAIT lasts 1 cycle (processing unit adder stage); next state CAPTURE.
REQ-019 CAPTURE: res_in sampled into out_data at the end of the cycle, i.e. 2 cycles after the ISSUE cycle; out_valid=1 from the following cycle; next state OUT.
REQ-020 OUT: out_valid and out_data held stable until out_ready=1; on the handshake out_valid drops next cycle and state returns to COLLECT.
REQ-021 in_ready=0 in ISSUE, WAIT, CAPTURE and OUT; no frame overlap.
REQ-022 Lanes hold their last written values outside COLLECT writes; they are never cleared except by rst.
REQ-023 flush=1 in any state: next state COLLECT, count=0, out_valid=0; partial frame and pending result are discarded; lanes are not cleared.
REQ-024 flush has priority over in_valid and out_ready in the same cycle; no handshake completes while flush=1.
REQ-025 No arithmetic on data; widths pass through unchanged at XLEN.

Reset
REQ-026 rst=1 forces state COLLECT, count=0, num1..num4=0, out_data=0, out_valid=0, lane_valid=0 immediately, regardless of clk.
REQ-027 in_ready=1 while in reset and on the first cycle after release; rst mid-frame discards all progress.

Configuration
REQ-028 Macro PU_LOADER_FRAME_CNT_EN defined: extra output frame_cnt (8 bits) counts completed output handshakes, wraps 255->0, cleared only by rst, unaffected by flush.
REQ-029 Macro undefined: frame_cnt port and counter are absent; all other behaviour is identical.

Structure
REQ-030 Shared package pu_loader_pkg holds: state encoding, LANES=4, PU_LATENCY=2, default XLEN=5.
REQ-031 Sub-module pu_lane_shift holds the four lane registers and the write-select by count; the FSM stays in pu_loader.

Verification
REQ-032 Words 1,2,3,4 with in_valid held high -> ISSUE in cycle 5 with num1..num4=1,2,3,4 and lane_valid=1; res_in=5'h0A in cycle 7 -> out_valid=1, out_data=5'h0A from cycle 8.
REQ-033 out_ready=0 for 10 cycles after out_valid rises -> out_data stable, in_ready=0 throughout; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
REQ-034 Gapped input (in_valid toggling 1,0,1,0...) with words 5'h1F,5'h00,5'h15,5'h0A -> lanes match arrival order; ISSUE follows the 4th accept only.
REQ-035 flush asserted after 2 accepted words -> count=0, next 4 words fill num1..num4 from num1; flush together with in_valid -> word not accepted (in_ready=0).
REQ-036 rst pulsed during WAIT -> out_valid=0, lanes=0, in_ready=1 immediately; res_in is never captured.
REQ-037 With PU_LOADER_FRAME_CNT_EN: 256 complete frames -> frame_cnt reads 0; one flushed frame -> frame_cnt unchanged.
